alien_formation: RTL and testbench

ALIEN_FORMATION -- requirements
Module: alien_formation

---
 rtl/alien_pkg.sv | 22 ++
 rtl/frame_tick_gen.sv | 41 ++++
 rtl/alien_formation.sv | 156 +++++++++++++++
 tb/tb_alien_formation.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// rtl/alien_pkg.sv - shared types and constants for the alien formation block
package alien_pkg;

  localparam int NUM_ALIENS = 15;
  localparam int ROWS       = 3;
  localparam int COLS       = 5;

  localparam logic [9:0] HIDDEN_COORD = 10'h3FF;

  typedef enum logic [1:0] {
    MOVE_RIGHT,
    MOVE_LEFT,
    DROP,
    HALT
  } form_state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame_clk synchroniser, rising-edge detect and step divider
module frame_tick_gen #(
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  input  logic restart,
  output logic step
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] TERM = CW'(FRAMES_PER_STEP - 1);

  // [0] metastable stage, [1] synchronised level, [2] previous level for edge detect
  logic [2:0]    sync_q;
  logic [CW-1:0] frame_cnt;
  logic          frame_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
    end
  end

  assign frame_tick = sync_q[1] & ~sync_q[2];
  assign step       = frame_tick && (frame_cnt == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (restart) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= (frame_cnt == TERM) ? '0 : frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alien_formation.sv
// rtl/alien_formation.sv - 3x5 alien formation: marching, edge drops, kills and halt
module alien_formation
  import alien_pkg::*;
#(
  parameter int X_START         = 64,
  parameter int Y_START         = 32,
  parameter int X_SPACING       = 48,
  parameter int Y_SPACING       = 40,
  parameter int ALIEN_SIZE      = 16,
  parameter int STEP_X          = 4,
  parameter int DROP_Y          = 16,
  parameter int X_MAX           = 639,
  parameter int X_MIN           = 0,
  parameter int Y_LIMIT         = 400,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_clk,
  input  logic                        restart,
  input  logic [NUM_ALIENS-1:0]       alien_kill,
  output logic [NUM_ALIENS-1:0][9:0]  AlienX,
  output logic [NUM_ALIENS-1:0][9:0]  AlienY,
  output logic [NUM_ALIENS-1:0]       alien_alive,
  output logic                        wave_cleared,
  output logic                        reached_bottom
);

  form_state_t           state, state_d;
  dir_t                  dir_next, dir_d;
  logic [9:0]            ox, oy, ox_d, oy_d;
  logic [NUM_ALIENS-1:0] alive, alive_d;
  logic                  cleared_d, bottom_d;
  logic                  step;

  logic [COLS-1:0]       col_live;
  logic [ROWS-1:0]       row_live;
  logic [2:0]            rc, lc;
  logic [1:0]            br;
  int                    right_edge, left_edge, bottom_edge;

  frame_tick_gen #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_tick (
    .clk      (Clk),
    .reset    (Reset),
    .frame_clk(frame_clk),
    .restart  (restart),
    .step     (step)
  );

  // Extent of the live formation, taken from the registered mask only
  always_comb begin
    col_live = '0;
    row_live = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      if (alive[i]) begin
        col_live[i % COLS] = 1'b1;
        row_live[i / COLS] = 1'b1;
      end
    end
    rc = '0;
    lc = '0;
    br = '0;
    for (int c = 0; c < COLS; c++)      if (col_live[c]) rc = 3'(c);
    for (int c = COLS - 1; c >= 0; c--) if (col_live[c]) lc = 3'(c);
    for (int r = 0; r < ROWS; r++)      if (row_live[r]) br = 2'(r);
  end

  assign right_edge  = int'(ox) + STEP_X + int'(rc) * X_SPACING + ALIEN_SIZE;
  assign left_edge   = int'(ox) + int'(lc) * X_SPACING;
  assign bottom_edge = int'(oy) + DROP_Y + int'(br) * Y_SPACING + ALIEN_SIZE;

  always_comb begin
    state_d   = state;
    dir_d     = dir_next;
    ox_d      = ox;
    oy_d      = oy;
    alive_d   = alive & ~alien_kill;
    cleared_d = wave_cleared;
    bottom_d  = reached_bottom;

    if (restart) begin
      state_d   = MOVE_RIGHT;
      dir_d     = DIR_RIGHT;
      ox_d      = 10'(X_START);
      oy_d      = 10'(Y_START);
      alive_d   = '1;
      cleared_d = 1'b0;
      bottom_d  = 1'b0;
    end else if (alive == '0) begin
      cleared_d = 1'b1;
      state_d   = HALT;
    end else begin
      case (state)
        MOVE_RIGHT: if (step) begin
          if (right_edge <= X_MAX) begin
            ox_d = ox + 10'(STEP_X);
          end else begin
            state_d = DROP;
            dir_d   = DIR_LEFT;
          end
        end
        MOVE_LEFT: if (step) begin
          if (left_edge >= X_MIN + STEP_X) begin
            ox_d = ox - 10'(STEP_X);
          end else begin
            state_d = DROP;
            dir_d   = DIR_RIGHT;
          end
        end
        // The drop resolves on the cycle after the edge step, so it lands with that frame
        DROP: begin
          oy_d = oy + 10'(DROP_Y);
          if (bottom_edge >= Y_LIMIT) begin
            state_d  = HALT;
            bottom_d = 1'b1;
          end else begin
            state_d = (dir_next == DIR_LEFT) ? MOVE_LEFT : MOVE_RIGHT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= MOVE_RIGHT;
      dir_next       <= DIR_RIGHT;
      ox             <= 10'(X_START);
      oy             <= 10'(Y_START);
      alive          <= '1;
      wave_cleared   <= 1'b0;
      reached_bottom <= 1'b0;
    end else begin
      state          <= state_d;
      dir_next       <= dir_d;
      ox             <= ox_d;
      oy             <= oy_d;
      alive          <= alive_d;
      wave_cleared   <= cleared_d;
      reached_bottom <= bottom_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALIENS; i++) begin
      AlienX[i] = alive[i] ? ox + 10'((i % COLS) * X_SPACING) : HIDDEN_COORD;
      AlienY[i] = alive[i] ? oy + 10'((i / COLS) * Y_SPACING) : HIDDEN_COORD;
    end
  end

  assign alien_alive = alive;

endmodule

// File: tb/tb_alien_formation.sv
// tb/tb_alien_formation.sv - randomized self-checking bench with a formation reference model
module tb_alien_formation;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, fclk, fclk_d, restart, restart_d;
  logic [14:0]      kill, kill_d;
  logic [14:0][9:0] ax, ay, ax_d, ay_d;
  logic [14:0]      alive_o, alive_od;
  logic             wc, rb, wc_d, rb_d;

  alien_formation #(.FRAMES_PER_STEP(1)) dut (
    .Clk(clk), .Reset(reset), .frame_clk(fclk), .restart(restart), .alien_kill(kill),
    .AlienX(ax), .AlienY(ay), .alien_alive(alive_o), .wave_cleared(wc), .reached_bottom(rb)
  );

  alien_formation dut_def (
    .Clk(clk), .Reset(reset), .frame_clk(fclk_d), .restart(restart_d), .alien_kill(kill_d),
    .AlienX(ax_d), .AlienY(ay_d), .alien_alive(alive_od), .wave_cleared(wc_d), .reached_bottom(rb_d)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 60) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: formation origin, direction, live mask, flags
  int          m_ox, m_oy, m_dir;
  logic [14:0] m_alive;
  bit          m_halt, m_bottom, m_cleared, m_valid;

  function automatic int rightmost(input logic [14:0] a);
    int r = -1;
    for (int i = 0; i < 15; i++) if (a[i] && (i % 5) > r) r = i % 5;
    return r;
  endfunction

  function automatic int leftmost(input logic [14:0] a);
    int r = 99;
    for (int i = 0; i < 15; i++) if (a[i] && (i % 5) < r) r = i % 5;
    return r;
  endfunction

  function automatic int lowest_row(input logic [14:0] a);
    int r = -1;
    for (int i = 0; i < 15; i++) if (a[i] && (i / 5) > r) r = i / 5;
    return r;
  endfunction

  task automatic model_reset();
    m_ox = 64; m_oy = 32; m_dir = 0; m_alive = 15'h7FFF;
    m_halt = 0; m_bottom = 0; m_cleared = 0;
  endtask

  task automatic model_kill(input logic [14:0] k);
    m_alive = m_alive & ~k;
    if (m_alive == 0) begin m_cleared = 1; m_halt = 1; end
  endtask

  task automatic model_step(input logic [14:0] k);
    logic [14:0] pre = m_alive;
    bit drop = 0;
    if (!m_halt) begin
      if (m_dir == 0) begin
        if (m_ox + 4 + rightmost(pre) * 48 + 16 <= 639) m_ox += 4;
        else begin drop = 1; m_dir = 1; end
      end else begin
        if (m_ox + leftmost(pre) * 48 >= 4) m_ox -= 4;
        else begin drop = 1; m_dir = 0; end
      end
    end
    m_alive = pre & ~k;
    if (m_alive == 0) begin
      m_cleared = 1; m_halt = 1;
    end else if (drop) begin
      m_oy += 16;
      if (m_oy + lowest_row(m_alive) * 40 + 16 >= 400) begin m_halt = 1; m_bottom = 1; end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (m_valid && !reset) begin
      chk("alive_mask", alive_o, m_alive);
      chk("wave_cleared", wc, m_cleared);
      chk("reached_bottom", rb, m_bottom);
      for (int i = 0; i < 15; i++) begin
        chk($sformatf("alien_x[%0d]", i), ax[i], m_alive[i] ? m_ox + (i % 5) * 48 : 1023);
        chk($sformatf("alien_y[%0d]", i), ay[i], m_alive[i] ? m_oy + (i / 5) * 40 : 1023);
      end
    end
  end

  // One frame pulse; optional kill lands in the same cycle as the resulting step
  task automatic pulse(input logic [14:0] k);
    fclk = 1;
    @(negedge clk);
    @(negedge clk);
    m_valid = 0;
    kill = k;
    @(negedge clk);
    kill = 0;
    fclk = 0;
    repeat (3) @(negedge clk);
    model_step(k);
    m_valid = 1;
  endtask

  task automatic kill_only(input logic [14:0] k);
    m_valid = 0;
    kill = k;
    @(negedge clk);
    kill = 0;
    @(negedge clk);
    model_kill(k);
    m_valid = 1;
  endtask

  task automatic do_restart();
    m_valid = 0;
    restart = 1;
    @(negedge clk);
    restart = 0;
    model_reset();
    m_valid = 1;
  endtask

  task automatic pulse_def();
    fclk_d = 1;
    repeat (3) @(negedge clk);
    fclk_d = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    reset = 1; fclk = 0; fclk_d = 0; restart = 0; restart_d = 0; kill = 0; kill_d = 0;
    m_valid = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    m_valid = 1;
    @(negedge clk);

    chk("reset_x7", ax[7], 160);
    chk("reset_y7", ay[7], 72);
    chk("reset_alive", alive_o, 15'h7FFF);
    chk("reset_cleared", wc, 0);
    chk("reset_bottom", rb, 0);

    repeat (7) pulse_def();
    chk("def_7_pulses_x0", ax_d[0], 64);
    pulse_def();
    chk("def_8_pulses_x0", ax_d[0], 68);

    repeat (91) pulse(0);
    chk("right_edge_x0", ax[0], 428);
    chk("right_edge_y0", ay[0], 32);
    pulse(0);
    chk("drop_y0", ay[0], 48);
    chk("drop_x0", ax[0], 428);
    pulse(0);
    chk("left_after_drop_x0", ax[0], 424);

    do_restart();
    kill_only(15'h4210);
    n = 0;
    while (m_oy == 32 && n < 300) begin pulse(0); n++; end
    chk("narrow_drop_bound", int'(n < 300), 1);
    chk("narrow_drop_x0", ax[0], 476);
    chk("narrow_drop_y0", ay[0], 48);
    chk("narrow_dead_x4", ax[4], 10'h3FF);

    // Reset while the formation sits in the drop cycle
    do_restart();
    repeat (91) pulse(0);
    fclk = 1;
    @(negedge clk);
    @(negedge clk);
    m_valid = 0;
    @(negedge clk);
    fclk = 0;
    chk("pre_drop_x0", ax[0], 428);
    reset = 1;
    #1;
    chk("mid_drop_reset_x0", ax[0], 64);
    chk("mid_drop_reset_x7", ax[7], 160);
    chk("mid_drop_reset_y7", ay[7], 72);
    chk("mid_drop_reset_alive", alive_o, 15'h7FFF);
    chk("mid_drop_reset_flags", {wc, rb}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    m_valid = 1;

    n = 0;
    while (!m_bottom && n < 3000) begin pulse(0); n++; end
    chk("bottom_bound", int'(n < 3000), 1);
    chk("bottom_flag", rb, 1);
    chk("bottom_y0", ay[0], 304);
    chk("bottom_x0", ax[0], 428);
    repeat (5) pulse(0);
    chk("bottom_frozen_x0", ax[0], 428);
    chk("bottom_frozen_y0", ay[0], 304);

    do_restart();
    for (int i = 0; i < 14; i++) kill_only(15'(1) << i);
    pulse(15'h4000);
    chk("cleared_flag", wc, 1);
    chk("cleared_alive", alive_o, 0);
    chk("cleared_x14", ax[14], 10'h3FF);
    repeat (3) pulse(0);
    chk("cleared_stays", wc, 1);
    do_restart();
    @(negedge clk);
    chk("restart_x7", ax[7], 160);
    chk("restart_y7", ay[7], 72);
    chk("restart_alive", alive_o, 15'h7FFF);
    chk("restart_cleared", wc, 0);

    for (int op = 0; op < 400; op++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      pulse(0);
      else if (r < 85) pulse(15'(1) << $urandom_range(0, 14));
      else if (r < 97) kill_only(15'(1) << $urandom_range(0, 14));
      else             do_restart();
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
